// File: rtl/parking_password_checker.sv
// Keypad passcode checker feeding the parking gate: collects BCD digits, grants on match, locks out after repeated failures.
// Grant or reject is visible two cycles after the enter strobe; there is no backpressure, keypad strobes are simply dropped when not accepted.
module parking_password_checker #(
  parameter int                      NUM_DIGITS     = 4,
  parameter logic [4*NUM_DIGITS-1:0] PASSCODE       = 16'h1234,
  parameter int                      MAX_TRIES      = 3,
  parameter int                      LOCK_CYCLES    = 16,
  parameter int                      TIMEOUT_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_digit,
  input  logic       i_key_clear,
  input  logic       i_key_enter,
  input  logic       i_release,
  output logic       o_password,
  output logic       o_pass_fail,
  output logic       o_locked,
  output logic       o_busy,
  output logic [3:0] o_digit_count
);

  localparam int BW   = 4 * NUM_DIGITS;
  localparam int CW   = $clog2(NUM_DIGITS + 1);
  localparam int TRW  = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0]  C_NUM_DIGITS = CW'(NUM_DIGITS);
  localparam logic [TRW-1:0] C_MAX_TRIES  = TRW'(MAX_TRIES);
  localparam logic [TW-1:0]  C_TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  C_LK_LAST    = TW'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_GRANT = 3'd3,
    S_DENY  = 3'd4,
    S_LOCK  = 3'd5
  } state_t;

  state_t         r_state;
  logic [BW-1:0]  r_buf;
  logic [CW-1:0]  r_cnt;
  logic [TRW-1:0] r_tries;
  logic [TW-1:0]  r_timer;

  state_t         w_state_nxt;
  logic [BW-1:0]  w_buf_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [TRW-1:0] w_tries_nxt;
  logic [TW-1:0]  w_timer_nxt;

  logic [BW-1:0]  w_buf_shift;
  logic [TRW-1:0] w_tries_inc;
  logic           w_digit_ok;
  logic           w_room;
  logic           w_match;

  // New digit enters at the LS nibble so the first-entered digit ends up in the MS nibble.
  assign w_buf_shift = (r_buf << 4) | BW'(i_key_digit);
  assign w_tries_inc = r_tries + TRW'(1);
  assign w_digit_ok  = (i_key_digit <= 4'd9);
  assign w_room      = (r_cnt < C_NUM_DIGITS);
  assign w_match     = (r_cnt == C_NUM_DIGITS) && (r_buf == PASSCODE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_tries <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tries <= w_tries_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_tries_nxt = r_tries;
    w_timer_nxt = r_timer;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_ENTRY;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
        end
      end
      S_ENTRY: begin
        if (i_key_clear) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
        end else if (i_key_enter) begin
          w_state_nxt = S_CHECK;
        end else if (i_key_valid) begin
          // Any keypress counts as activity, even one that is not buffered.
          w_timer_nxt = '0;
          if (w_digit_ok && w_room) begin
            w_buf_nxt = w_buf_shift;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else if (r_timer >= C_TO_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_CHECK: begin
        if (w_match) begin
          w_state_nxt = S_GRANT;
          w_tries_nxt = '0;
        end else begin
          w_state_nxt = S_DENY;
        end
      end
      S_GRANT: begin
        if (i_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DENY: begin
        w_tries_nxt = w_tries_inc;
        w_timer_nxt = '0;
        if (w_tries_inc == C_MAX_TRIES) begin
          w_state_nxt = S_LOCK;
        end else begin
          w_state_nxt = S_ENTRY;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_LOCK: begin
        if (r_timer >= C_LK_LAST) begin
          w_state_nxt = S_IDLE;
          w_tries_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    o_password    = (r_state == S_GRANT);
    o_pass_fail   = (r_state == S_DENY);
    o_locked      = (r_state == S_LOCK);
    o_busy        = (r_state != S_IDLE);
    o_digit_count = 4'(r_cnt);
  end

endmodule
